inc_arbiter: RTL and testbench

INC_ARBITER -- requirements
Module: inc_arbiter

---
 rtl/inc_arbiter.sv | 120 ++++++++++++
 tb/tb_inc_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_arbiter.sv
// Four-way round-robin arbiter feeding a single shared incrementer.
// One request is serviced at a time: accept (IDLE), compute (EXEC), hand back (RESP).
module inc_arbiter #(
  parameter int unsigned P_EXEC_CYCLES = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  REQ_I,
  input  logic [31:0] REQ_DATA_I,
  output logic [3:0]  GNT_O,
  output logic        RSP_VALID_O,
  input  logic        RSP_READY_I,
  output logic [7:0]  RSP_DATA_O,
  output logic        RSP_OVF_O,
  output logic [1:0]  RSP_ID_O,
  output logic        BUSY_O
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] C_CNT_LOAD = 4'(P_EXEC_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [7:0] r_op;
  logic [1:0] r_id;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_ovf;
  logic [1:0] r_rsp_id;

  logic [1:0] w_cand_idx [4];
  logic [3:0] w_cand_hit;
  logic       w_hit;
  logic [1:0] w_idx;
  logic       w_grant;
  logic [7:0] w_grant_op;
  logic [8:0] w_sum;

  // Candidate gi is the requester gi places after the pointer, wrapping mod 4.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand_idx[gi] = r_ptr + 2'(gi);
      assign w_cand_hit[gi] = REQ_I[w_cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the closest requester to the pointer wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_cand_hit[k]) begin
        w_hit = 1'b1;
        w_idx = w_cand_idx[k];
      end
    end
  end

  assign w_grant    = (r_state == ST_IDLE) && !RST_I && w_hit;
  assign GNT_O      = w_grant ? (4'b0001 << w_idx) : 4'b0000;
  assign w_grant_op = REQ_DATA_I[8*w_idx +: 8];
  assign w_sum      = {1'b0, r_op} + 9'd1;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= 4'd0;
      r_op        <= 8'd0;
      r_id        <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_id    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_op    <= w_grant_op;
            r_id    <= w_idx;
            r_cnt   <= C_CNT_LOAD;
            r_ptr   <= w_idx + 2'd1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_data  <= w_sum[7:0];
            r_rsp_ovf   <= w_sum[8];
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Response fields are left untouched so they read back after the handshake.
          if (RSP_READY_I) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RSP_VALID_O = r_rsp_valid;
  assign RSP_DATA_O  = r_rsp_data;
  assign RSP_OVF_O   = r_rsp_ovf;
  assign RSP_ID_O    = r_rsp_id;
  assign BUSY_O      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: scenario tasks push expected responses, a negedge
// monitor pops and compares them whenever a response handshake occurs.
module tb_inc_arbiter;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        RST_I = 1'b1;
  logic [3:0]  REQ_I = 4'd0;
  logic [31:0] REQ_DATA_I = 32'd0;
  logic        RSP_READY_I = 1'b1;
  logic [3:0]  GNT_O;
  logic        RSP_VALID_O;
  logic [7:0]  RSP_DATA_O;
  logic        RSP_OVF_O;
  logic [1:0]  RSP_ID_O;
  logic        BUSY_O;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  inc_arbiter #(.P_EXEC_CYCLES(P)) dut (
    .CLK_I       (clk),
    .RST_I       (RST_I),
    .REQ_I       (REQ_I),
    .REQ_DATA_I  (REQ_DATA_I),
    .GNT_O       (GNT_O),
    .RSP_VALID_O (RSP_VALID_O),
    .RSP_READY_I (RSP_READY_I),
    .RSP_DATA_O  (RSP_DATA_O),
    .RSP_OVF_O   (RSP_OVF_O),
    .RSP_ID_O    (RSP_ID_O),
    .BUSY_O      (BUSY_O)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] id, input logic [7:0] op);
    logic [8:0] s;
    s = {1'b0, op} + 9'd1;
    mk.id   = id;
    mk.data = s[7:0];
    mk.ovf  = s[8];
  endfunction

  // Scoreboard monitor: a response completes at the edge after valid && ready.
  always @(negedge clk) begin
    if (!RST_I && RSP_VALID_O === 1'b1 && RSP_READY_I) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d data=%02h ovf=%0b, required no response",
                 RSP_ID_O, RSP_DATA_O, RSP_OVF_O);
      end else begin
        mon_e = sb.pop_front();
        if ({RSP_ID_O, RSP_DATA_O, RSP_OVF_O} !== {mon_e.id, mon_e.data, mon_e.ovf}) begin
          errors++;
          $display("FAIL sb_response: got id=%0d data=%02h ovf=%0b, required id=%0d data=%02h ovf=%0b",
                   RSP_ID_O, RSP_DATA_O, RSP_OVF_O, mon_e.id, mon_e.data, mon_e.ovf);
        end
      end
      $display("rsp handshake: id=%0d data=%02h ovf=%0b", RSP_ID_O, RSP_DATA_O, RSP_OVF_O);
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (BUSY_O === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1; REQ_I = 4'hF; RSP_READY_I = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'd0) begin
      errors++; $display("FAIL reset_gnt: got %b, required 0000", GNT_O);
    end
    @(posedge clk); #1;
    RST_I = 1'b0; REQ_I = 4'd0;
    @(negedge clk);
    checks++;
    if ({BUSY_O, RSP_VALID_O, RSP_DATA_O, RSP_OVF_O, RSP_ID_O, GNT_O} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b data=%02h ovf=%b id=%0d gnt=%b, required all zero",
               BUSY_O, RSP_VALID_O, RSP_DATA_O, RSP_OVF_O, RSP_ID_O, GNT_O);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit ok;
    @(posedge clk); #1;
    REQ_I = 4'b0100; REQ_DATA_I = 32'h003C_0000;
    sb.push_back(mk(2'd2, 8'h3C));
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'b0100) begin
      errors++; $display("FAIL basic_gnt: got %b, required 0100", GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    @(negedge clk);
    checks++;
    if ({GNT_O, BUSY_O, RSP_VALID_O} !== 6'b0000_10) begin
      errors++; $display("FAIL basic_exec1: got gnt=%b busy=%b valid=%b, required 0000/1/0", GNT_O, BUSY_O, RSP_VALID_O);
    end
    @(negedge clk);
    checks++;
    if (RSP_VALID_O !== 1'b0) begin
      errors++; $display("FAIL basic_exec2: got valid=%b, required 0", RSP_VALID_O);
    end
    @(negedge clk);
    checks++;
    if ({RSP_VALID_O, RSP_DATA_O, RSP_OVF_O, RSP_ID_O} !== {1'b1, 8'h3D, 1'b0, 2'd2}) begin
      errors++; $display("FAIL basic_latency: got valid=%b data=%02h ovf=%b id=%0d, required 1/3d/0/2",
                         RSP_VALID_O, RSP_DATA_O, RSP_OVF_O, RSP_ID_O);
    end
    @(negedge clk);
    checks++;
    if ({RSP_VALID_O, BUSY_O, RSP_DATA_O, RSP_ID_O} !== {1'b0, 1'b0, 8'h3D, 2'd2}) begin
      errors++; $display("FAIL basic_retain: got valid=%b busy=%b data=%02h id=%0d, required 0/0/3d/2",
                         RSP_VALID_O, BUSY_O, RSP_DATA_O, RSP_ID_O);
    end
    wait_idle(ok);
    $display("test_basic done");
  endtask

  task automatic test_ovf();
    bit ok;
    bit seen;
    @(posedge clk); #1;
    REQ_I = 4'b0010; REQ_DATA_I = 32'h0000_FF00;
    sb.push_back(mk(2'd1, 8'hFF));
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'b0010) begin
      errors++; $display("FAIL ovf_gnt: got %b, required 0010", GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (RSP_VALID_O === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || {RSP_DATA_O, RSP_OVF_O, RSP_ID_O} !== {8'h00, 1'b1, 2'd1}) begin
      errors++; $display("FAIL ovf_result: got seen=%b data=%02h ovf=%b id=%0d, required 1/00/1/1",
                         seen, RSP_DATA_O, RSP_OVF_O, RSP_ID_O);
    end
    wait_idle(ok);
    $display("test_ovf done");
  endtask

  task automatic test_round_robin();
    bit ok;
    int g = 0;
    int last = 0;
    @(posedge clk); #1; RST_I = 1'b1;
    @(posedge clk); #1; RST_I = 1'b0;
    REQ_DATA_I = 32'h4030_2010; REQ_I = 4'hF;
    for (int i = 0; i < 8; i++) sb.push_back(mk(2'(i % 4), 8'(16 * (i % 4 + 1))));
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (GNT_O !== 4'd0) begin
        checks++;
        if (GNT_O !== (4'b0001 << (g % 4))) begin
          errors++; $display("FAIL rr_order: grant %0d got %b, required %b", g, GNT_O, 4'b0001 << (g % 4));
        end
        if (g > 0) begin
          checks++;
          if (cyc - last != P + 2) begin
            errors++; $display("FAIL rr_spacing: grant %0d got %0d cycles, required %0d", g, cyc - last, P + 2);
          end
        end
        $display("rr grant %0d: gnt=%b cycle=%0d", g, GNT_O, cyc);
        last = cyc;
        g++;
        if (g == 8) break;
      end
    end
    checks++;
    if (g != 8) begin
      errors++; $display("FAIL rr_count: got %0d grants, required 8", g);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_idle: got busy timeout, required idle");
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    @(posedge clk); #1;
    RSP_READY_I = 1'b0; REQ_I = 4'b0100; REQ_DATA_I = 32'h007E_0000;
    sb.push_back(mk(2'd2, 8'h7E));
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'b0100) begin
      errors++; $display("FAIL bp_gnt: got %b, required 0100", GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (RSP_VALID_O === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_valid: got no valid, required valid");
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        REQ_I = 4'b0001; REQ_DATA_I = 32'h0000_0011;
        sb.push_back(mk(2'd0, 8'h11));
      end
      @(negedge clk);
      checks++;
      if ({RSP_VALID_O, BUSY_O, RSP_DATA_O, RSP_ID_O, RSP_OVF_O, GNT_O} !== {1'b1, 1'b1, 8'h7F, 2'd2, 1'b0, 4'd0}) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b busy=%b data=%02h id=%0d ovf=%b gnt=%b, required 1/1/7f/2/0/0000",
                           k, RSP_VALID_O, BUSY_O, RSP_DATA_O, RSP_ID_O, RSP_OVF_O, GNT_O);
      end
    end
    @(posedge clk); #1;
    RSP_READY_I = 1'b1;
    @(negedge clk);
    checks++;
    if ({GNT_O, RSP_VALID_O} !== 5'b0000_1) begin
      errors++; $display("FAIL bp_ready_cycle: got gnt=%b valid=%b, required 0000/1", GNT_O, RSP_VALID_O);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({GNT_O, BUSY_O} !== 5'b0001_0) begin
      errors++; $display("FAIL bp_next_gnt: got gnt=%b busy=%b, required 0001/0", GNT_O, BUSY_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    wait_idle(ok);
    $display("test_backpressure done");
  endtask

  task automatic test_reset_exec();
    bit ok;
    @(posedge clk); #1;
    REQ_I = 4'b0100; REQ_DATA_I = 32'h0022_0000;
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'b0100) begin
      errors++; $display("FAIL rst_exec_gnt: got %b, required 0100", GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0; RST_I = 1'b1;
    @(negedge clk);
    checks++;
    if ({GNT_O, BUSY_O} !== 5'b0000_1) begin
      errors++; $display("FAIL rst_exec_busy: got gnt=%b busy=%b, required 0000/1", GNT_O, BUSY_O);
    end
    @(posedge clk); #1;
    RST_I = 1'b0; REQ_I = 4'b1010; REQ_DATA_I = 32'h0000_9900;
    sb.push_back(mk(2'd1, 8'h99));
    @(negedge clk);
    checks++;
    if ({BUSY_O, RSP_VALID_O, RSP_DATA_O, RSP_ID_O, RSP_OVF_O, GNT_O} !== {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0010}) begin
      errors++; $display("FAIL rst_exec_after: got busy=%b valid=%b data=%02h id=%0d ovf=%b gnt=%b, required 0/0/00/0/0/0010",
                         BUSY_O, RSP_VALID_O, RSP_DATA_O, RSP_ID_O, RSP_OVF_O, GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    wait_idle(ok);
    $display("test_reset_exec done");
  endtask

  task automatic test_req_change();
    bit ok;
    bit done;
    @(posedge clk); #1;
    REQ_I = 4'b0001; REQ_DATA_I = 32'h0000_0055;
    sb.push_back(mk(2'd0, 8'h55));
    @(negedge clk);
    checks++;
    if (GNT_O !== 4'b0001) begin
      errors++; $display("FAIL chg_first_gnt: got %b, required 0001", GNT_O);
    end
    @(posedge clk); #1;
    REQ_I = 4'b1000;
    sb.push_back(mk(2'd3, 8'h00));
    done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      checks++;
      if (BUSY_O === 1'b1) begin
        if (GNT_O !== 4'd0) begin
          errors++; $display("FAIL chg_busy_gnt: got %b, required 0000", GNT_O);
        end
      end else begin
        if (GNT_O !== 4'b1000) begin
          errors++; $display("FAIL chg_idle_gnt: got %b, required 1000", GNT_O);
        end
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL chg_timeout: got busy throughout, required return to idle");
    end
    @(posedge clk); #1;
    REQ_I = 4'd0;
    wait_idle(ok);
    repeat (2) @(negedge clk);
    $display("test_req_change done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_req_change();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
